mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle multiply/divide engine between the datapath bus and the HI/LO registers.
//   Operand A comes from the Y register output and operand B from BusMuxOut.
//   It computes a 2*WIDTH-bit product, or a quotient/remainder pair.
//   hi_out/lo_out feed the D inputs of HI/LO; the control unit pulses HIin/LOin on done.
// PARAMETERS
//   WIDTH     32   operand width; hi_out and lo_out are each WIDTH bits
//   CNT_W     6    iteration-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk       in   1      rising-edge clock
//   clr       in   1      asynchronous active-high reset
//   start     in   1      request; sampled only in IDLE
//   op_div    in   1      0 = multiply, 1 = divide; latched with start
//   op_sgn    in   1      1 = signed operation; latched with start; see CONFIGURATION
//   a_in      in   WIDTH  multiplicand / dividend (Y register)
//   b_in      in   WIDTH  multiplier / divisor (BusMuxOut)
//   busy      out  1      high from the edge after start is accepted until done
//   done      out  1      one-cycle pulse; hi_out/lo_out are valid from this cycle on
//   div_zero  out  1      high together with done when divide had b_in == 0
//   hi_out    out  WIDTH  mul: product[2W-1:W]; div: remainder
//   lo_out    out  WIDTH  mul: product[W-1:0];  div: quotient
// BEHAVIOUR
//   Reset (clr=1, asynchronous):
//     - state = IDLE; all outputs 0, including busy, done, div_zero, hi_out, lo_out.
//     - clr during CALC aborts the operation; no done is produced.
//   FSM states: IDLE -> CALC -> FIN -> IDLE.
//   IDLE:
//     - On an edge with start=1: latch op_div, op_sgn and operand magnitudes; cnt = 0; go to CALC.
//     - start=0: stay in IDLE.
//   CALC (busy=1): one radix-2 step per edge; cnt++; after WIDTH steps go to FIN.
//     - Multiply: shift-add into a 2W accumulator.
//     - Divide: restoring division on a {rem, quot} shift register.
//   FIN (busy=1): apply sign fix-up, write hi_out/lo_out; done=1 next cycle; go to IDLE.
//   Latency:
//     - Start accepted at edge N; done is high during the cycle after edge N+WIDTH+1 (33 edges for W=32).
//     - Back-to-back: start may be asserted in the same cycle done is high; it is accepted at the next edge.
//   Start rules:
//     - start while busy is ignored and not queued.
//     - Operand changes after acceptance have no effect.
//   Result holding: hi_out/lo_out hold until the next FIN or clr; done and div_zero last one cycle.
//   Divide by zero (b_in==0):
//     - Full latency still applies.
//     - lo_out = all ones; hi_out = dividend as presented; div_zero = 1 with done.
//   Arithmetic: no overflow flag.
//     - Multiply result is exact in 2W bits.
//     - Signed INT_MIN / -1: lo_out = INT_MIN, hi_out = 0.
// CONFIGURATION
//   MULDIV_SIGNED_EN defined:
//     - op_sgn=1 makes the engine operate on absolute values.
//     - Product is negated if sign(a)^sign(b).
//     - Quotient is negated if sign(a)^sign(b); remainder takes the sign of the dividend.
//   MULDIV_SIGNED_EN undefined:
//     - op_sgn is ignored; all operations are unsigned.
//     - No sign logic is synthesized; latency is unchanged.
// TESTING
//   1. Unsigned mul 32'h0000_FFFF * 32'h0001_0000 -> done at edge N+33; hi=0, lo=32'hFFFF_0000; busy high for 33 cycles.
//   2. Unsigned div 100 / 7 -> lo=14, hi=2, div_zero=0; mul 32'hFFFF_FFFF * 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=1.
//   3. Div 1234 / 0 -> lo=32'hFFFF_FFFF, hi=1234, div_zero=1 for exactly the done cycle.
//   4. MULDIV_SIGNED_EN:
//        - Signed mul -6*7: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFD6.
//        - Signed div -7/2: lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
//      Without the macro, div -7/2 gives the unsigned result: lo=32'h7FFF_FFFC, hi=1.
//   5. Start pulsed mid-CALC with new operands -> ignored; result matches the first operands; one done only.
//   6. clr asserted asynchronously at edge N+10 of a multiply -> busy, hi_out, lo_out drop to 0 immediately; no done.
//      A later start completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle radix-2 multiply / restoring-divide engine feeding the HI/LO registers.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_sgn,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_div, dz_r;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic sgn_a, sgn_b, neg_res, neg_rem;
    logic [2*WIDTH-1:0] prod;

    assign sgn_a = op_sgn & a_in[WIDTH-1];
    assign sgn_b = op_sgn & b_in[WIDTH-1];
    assign a_mag = sgn_a ? -a_in : a_in;
    assign b_mag = sgn_b ? -b_in : b_in;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
        end
    end

    // Engine works on magnitudes; signs are restored only once, at FIN.
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign quot_fix = neg_res ? -acc_lo : acc_lo;
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;
`else
    logic unused_sgn;

    assign unused_sgn = op_sgn;
    assign a_mag      = a_in;
    assign b_mag      = b_in;
    assign prod_fix   = {acc_hi, acc_lo};
    assign quot_fix   = acc_lo;
    assign rem_fix    = acc_hi;
`endif

    // One radix-2 step. Multiply shifts right through {acc_hi, acc_lo};
    // divide shifts left with acc_hi as partial remainder, acc_lo as quotient.
    always_comb begin
        step_hi  = acc_hi;
        step_lo  = acc_lo;
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (!rem_diff[WIDTH]) begin
                step_hi = rem_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CALC;
            end
            CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            dz_r     <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    is_div <= op_div;
                    dz_r   <= op_div && (b_in == '0);
                    a_raw  <= a_in;
                    acc_hi <= '0;
                    acc_lo <= op_div ? a_mag : b_mag;
                    opnd   <= op_div ? b_mag : a_mag;
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIN: begin
                    done     <= 1'b1;
                    div_zero <= dz_r;
                    if (dz_r) begin
                        // Divide by zero reports the dividend untouched, not its magnitude.
                        hi_out <= a_raw;
                        lo_out <= '1;
                    end else if (is_div) begin
                        hi_out <= rem_fix;
                        lo_out <= quot_fix;
                    end else begin
                        {hi_out, lo_out} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        clr, start, op_div, op_sgn;
    logic [31:0] a_in, b_in;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .clr(clr), .start(start), .op_div(op_div), .op_sgn(op_sgn),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic void model(input logic d, input logic s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] eh,
                                  output logic [31:0] el, output logic ez);
        logic   use_sgn;
        longint sp;
        logic [63:0] up;
        use_sgn = SGN_EN && s;
        ez = 1'b0;
        eh = '0;
        el = '0;
        if (d && b == 32'd0) begin
            eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (use_sgn && !d) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {eh, el} = sp;
        end else if (use_sgn && d) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                el = a; eh = '0;
            end else begin
                el = $signed(a) / $signed(b);
                eh = $signed(a) % $signed(b);
            end
        end else if (!d) begin
            up = {32'd0, a} * {32'd0, b};
            {eh, el} = up;
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op_div = d; op_sgn = s; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_div = ~d; op_sgn = ~s; a_in = $urandom; b_in = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input logic [31:0] eh, input logic [31:0] el,
                             input logic ez, input string nm);
        int edges = 0;
        int bcnt  = 0;
        while (!done && edges < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, 64'(edges), 64'(exp_lat));
        chk({nm, "_busycyc"}, 64'(bcnt), 64'(exp_lat));
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, "_hi"}, 64'(hi_out), 64'(eh));
        chk({nm, "_lo"}, 64'(lo_out), 64'(el));
        chk({nm, "_dz"}, 64'(div_zero), 64'(ez));
    endtask

    task automatic check_hold(input logic [31:0] eh, input logic [31:0] el, input string nm);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_done_pulse"}, 64'(done), 64'd0);
        chk({nm, "_dz_pulse"}, 64'(div_zero), 64'd0);
        chk({nm, "_hold_hi"}, 64'(hi_out), 64'(eh));
        chk({nm, "_hold_lo"}, 64'(lo_out), 64'(el));
    endtask

    task automatic run_model(input logic d, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input string nm);
        logic [31:0] eh, el;
        logic        ez;
        model(d, s, a, b, eh, el, ez);
        @(negedge clk);
        launch(d, s, a, b);
        wait_done(33, eh, el, ez, nm);
        check_hold(eh, el, nm);
    endtask

    initial begin
        logic [31:0] eh, el, eh2, el2;
        logic        ez, ez2;
        int          ndone;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_FFFF, 32'h0001_0000, 32'h0, 32'hFFFF_0000, 1'b0, "mul_ffff"};
        tbl[1] = '{1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div_100_7"};
        tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, "mul_max"};
        tbl[3] = '{1'b1, 1'b0, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1'b1, "div_by0"};
        tbl[4] = '{1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, "mul_zero"};
        tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "sdiv_by0"};
`ifdef MULDIV_SIGNED_EN
        tbl[6] = '{1'b0, 1'b1, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, "smul_m6_7"};
        tbl[7] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "sdiv_m7_2"};
        tbl[8] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "sdiv_min_m1"};
        tbl[9] = '{1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, "sdiv_7_m2"};
`else
        tbl[6] = '{1'b0, 1'b1, 32'hFFFF_FFFA, 32'd7, 32'h6, 32'hFFFF_FFD6, 1'b0, "smul_m6_7"};
        tbl[7] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, "sdiv_m7_2"};
        tbl[8] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, "sdiv_min_m1"};
        tbl[9] = '{1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'h0, 1'b0, "sdiv_7_m2"};
`endif

        clr = 1'b1; start = 1'b0; op_div = 1'b0; op_sgn = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            launch(tbl[i].d, tbl[i].s, tbl[i].a, tbl[i].b);
            wait_done(33, tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].name);
            check_hold(tbl[i].hi, tbl[i].lo, tbl[i].name);
        end

        // Back-to-back: second start presented during the done cycle.
        model(1'b1, 1'b0, 32'd1000, 32'd33, eh, el, ez);
        model(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, eh2, el2, ez2);
        @(negedge clk);
        launch(1'b1, 1'b0, 32'd1000, 32'd33);
        wait_done(33, eh, el, ez, "b2b_first");
        launch(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(33, eh2, el2, ez2, "b2b_second");
        check_hold(eh2, el2, "b2b_second");

        // Start pulsed mid-CALC with new operands must be ignored.
        model(1'b0, 1'b0, 32'd1234567, 32'd89, eh, el, ez);
        @(negedge clk);
        launch(1'b0, 1'b0, 32'd1234567, 32'd89);
        start = 1'b1; op_div = 1'b1; a_in = 32'd999; b_in = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        wait_done(29, eh, el, ez, "midstart");
        check_hold(eh, el, "midstart");
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midstart_extra_done", 64'(ndone), 64'd0);

        // Asynchronous clear at edge N+10 of a multiply aborts it.
        @(negedge clk);
        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003);
        repeat (10) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_hi", 64'(hi_out), 64'd0);
        chk("clr_lo", 64'(lo_out), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("clr_no_done", 64'(ndone), 64'd0);
        run_model(1'b1, 1'b0, 32'd100, 32'd7, "after_clr");

        for (int i = 0; i < 40; i++) begin
            logic        d, s;
            logic [31:0] a, b;
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; d = 1'b1; s = 1'b1; end
            run_model(d, s, a, b, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
